// File: rtl/sudoku_report_pkg.sv
// Shared constants, FSM encoding and ASCII helpers for the sudoku report
// transmitter.
package sudoku_report_pkg;

   localparam int MSG_LEN       = 24;
   localparam int BITS_PER_CHAR = 10;

   localparam logic [7:0] CH_C  = 8'h43;
   localparam logic [7:0] CH_W  = 8'h57;
   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_EQ = 8'h3D;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   typedef logic [1:0] tx_state_t;
   localparam tx_state_t ST_IDLE  = 2'd0;
   localparam tx_state_t ST_START = 2'd1;
   localparam tx_state_t ST_DATA  = 2'd2;
   localparam tx_state_t ST_STOP  = 2'd3;

   // 'A' (0x41) is 0x37 + 10, so one offset covers all letter digits.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      hex_ascii = (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h37 + {4'd0, nib});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A frame starts on i_valid && o_ready; the byte itself
// is sampled at the end of the start bit, so the caller may update its
// character selection on the accept edge.
module uart_tx_byte
   import sudoku_report_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_txd
);

   tx_state_t   r_state;
   logic [15:0] r_baud;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_txd;
   logic        w_wrap;
   logic        w_accept;

   assign w_wrap   = (r_baud == 16'(CLK_DIV - 1));
   // Ready on the last stop-bit cycle too, so characters run back to back.
   assign o_ready  = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_wrap);
   assign w_accept = i_valid && o_ready;
   assign o_txd    = r_txd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_txd   <= 1'b1;
      end else if (w_accept) begin
         r_state <= ST_START;
         r_baud  <= '0;
         r_txd   <= 1'b0;
      end else if (r_state != ST_IDLE) begin
         r_baud <= w_wrap ? 16'd0 : r_baud + 16'd1;
         if (w_wrap) begin
            case (r_state)
               ST_START: begin
                  r_state <= ST_DATA;
                  r_bit   <= '0;
                  r_txd   <= i_data[0];
               end
               ST_DATA: begin
                  if (r_bit == 3'd7) begin
                     r_state <= ST_STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_txd <= r_shift[0];
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_txd   <= 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == ST_START) && w_wrap)
         r_shift <= {1'b1, i_data[7:1]};
      else if ((r_state == ST_DATA) && w_wrap)
         r_shift <= {1'b1, r_shift[7:1]};
   end

endmodule

// File: rtl/sudoku_report_tx.sv
// Snapshots the sudoku checker counters on an auto or manual trigger and
// sends them as one ASCII line "C=ccc W=www T=tttttttt\r\n" over 8N1 UART.
module sudoku_report_tx
   import sudoku_report_pkg::*;
#(
   parameter int CLK_DIV     = 434,
   parameter int NUM_PUZZLES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  num_correct,
   input  logic [9:0]  num_wrong,
   input  logic [31:0] cycles,
   input  logic        report_req,
   output logic        txd,
   output logic        busy,
   output logic        done
);

   logic        r_busy;
   logic        r_done;
   logic        r_pending;
   logic        r_armed;
   logic [4:0]  r_idx;
   logic [9:0]  r_snap_c;
   logic [9:0]  r_snap_w;
   logic [31:0] r_snap_t;

   logic [10:0] w_total;
   logic        w_auto;
   logic        w_trig;
   logic        w_ready;
   logic        w_char_end;
   logic        w_line_end;
   logic        w_next_char;
   logic        w_start;
   logic        w_valid;
   logic [7:0]  w_char;
   logic        w_txd;

   assign w_total = {1'b0, num_correct} + {1'b0, num_wrong};
   assign w_auto  = r_armed && (w_total >= 11'(NUM_PUZZLES));
   assign w_trig  = w_auto || report_req;

   // While busy the serializer is only ready at the end of a stop bit.
   assign w_char_end  = r_busy && w_ready;
   assign w_line_end  = w_char_end && (r_idx == 5'(MSG_LEN - 1));
   assign w_next_char = w_char_end && !w_line_end;
   assign w_start     = (!r_busy && w_trig) || (w_line_end && (r_pending || w_trig));
   assign w_valid     = w_start || w_next_char;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pending <= 1'b0;
         r_armed   <= 1'b1;
         r_idx     <= '0;
      end else begin
         r_done <= w_line_end;
         if (w_auto)
            r_armed <= 1'b0;
         if (w_start) begin
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_pending <= 1'b0;
         end else if (w_line_end) begin
            r_busy <= 1'b0;
         end else begin
            if (w_next_char)
               r_idx <= r_idx + 5'd1;
            if (r_busy && w_trig)
               r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_start) begin
         r_snap_c <= num_correct;
         r_snap_w <= num_wrong;
         r_snap_t <= cycles;
      end
   end

   always_comb begin
      w_char = CH_LF;
      case (r_idx)
         5'd0:  w_char = CH_C;
         5'd1:  w_char = CH_EQ;
         5'd2:  w_char = hex_ascii({2'b00, r_snap_c[9:8]});
         5'd3:  w_char = hex_ascii(r_snap_c[7:4]);
         5'd4:  w_char = hex_ascii(r_snap_c[3:0]);
         5'd5:  w_char = CH_SP;
         5'd6:  w_char = CH_W;
         5'd7:  w_char = CH_EQ;
         5'd8:  w_char = hex_ascii({2'b00, r_snap_w[9:8]});
         5'd9:  w_char = hex_ascii(r_snap_w[7:4]);
         5'd10: w_char = hex_ascii(r_snap_w[3:0]);
         5'd11: w_char = CH_SP;
         5'd12: w_char = CH_T;
         5'd13: w_char = CH_EQ;
         5'd14: w_char = hex_ascii(r_snap_t[31:28]);
         5'd15: w_char = hex_ascii(r_snap_t[27:24]);
         5'd16: w_char = hex_ascii(r_snap_t[23:20]);
         5'd17: w_char = hex_ascii(r_snap_t[19:16]);
         5'd18: w_char = hex_ascii(r_snap_t[15:12]);
         5'd19: w_char = hex_ascii(r_snap_t[11:8]);
         5'd20: w_char = hex_ascii(r_snap_t[7:4]);
         5'd21: w_char = hex_ascii(r_snap_t[3:0]);
         5'd22: w_char = CH_CR;
         default: w_char = CH_LF;
      endcase
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid),
      .i_data  (w_char),
      .o_ready (w_ready),
      .o_txd   (w_txd)
   );

   assign txd  = w_txd;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_sudoku_report_tx.sv
// Directed bench for sudoku_report_tx at CLK_DIV=4, NUM_PUZZLES=10; a
// background receiver decodes txd into a byte buffer.
module tb_sudoku_report_tx;

   localparam int CLK_DIV     = 4;
   localparam int NUM_PUZZLES = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  num_correct = '0;
   logic [9:0]  num_wrong = '0;
   logic [31:0] cycles = '0;
   logic        report_req = 1'b0;
   logic        txd;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] rx_buf [0:511];
   int rx_n     = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   sudoku_report_tx #(
      .CLK_DIV     (CLK_DIV),
      .NUM_PUZZLES (NUM_PUZZLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .num_correct (num_correct),
      .num_wrong   (num_wrong),
      .cycles      (cycles),
      .report_req  (report_req),
      .txd         (txd),
      .busy        (busy),
      .done        (done)
   );

   initial forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
   end

   // Sample each bit in the middle of its 4-cycle period.
   initial forever begin
      logic [7:0] ch;
      @(negedge clk);
      if (txd === 1'b0) begin
         repeat (2) @(negedge clk);
         for (int b = 0; b < 8; b++) begin
            repeat (4) @(negedge clk);
            ch[b] = txd;
         end
         repeat (4) @(negedge clk);
         if (rx_n < 512) rx_buf[rx_n] = ch;
         rx_n++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic string printable(input logic [7:0] c);
      if (c === 8'h0D) return "<CR>";
      if (c === 8'h0A) return "<LF>";
      return $sformatf("%c", c);
   endfunction

   task automatic expect_line(input string tag, input int base, input string exp);
      string got;
      string want;
      int k;
      got = "";
      k = 0;
      while (rx_n < base + 24 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 24; i++) begin
         if (base + i < rx_n && base + i < 512) got = {got, printable(rx_buf[base + i])};
         else got = {got, "?"};
      end
      want = {exp, "<CR><LF>"};
      n_tests++;
      assert (got == want) else begin
         n_fail++;
         $error("FAIL %s: got \"%s\" expected \"%s\"", tag, got, want);
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base;
      int b0;
      int d0;

      repeat (3) @(negedge clk);
      chk("reset_txd", 64'(txd), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);

      // Auto trigger: total climbs 3..10
      num_wrong = 10'd3;
      cycles    = 32'h0000002A;
      rst       = 1'b0;
      for (int v = 1; v <= 6; v++) begin
         @(negedge clk);
         num_correct = 10'(v);
      end
      @(negedge clk);
      chk("auto_not_early", 64'(busy), 64'd0);
      d0 = done_cnt;
      base = rx_n;
      num_correct = 10'd7;
      @(negedge clk);
      chk("auto_busy", 64'(busy), 64'd1);
      chk("auto_start_bit", 64'(txd), 64'd0);
      expect_line("auto_line", base, "C=007 W=003 T=0000002A");
      wait_idle("auto_idle");
      b0 = busy_cnt;
      num_correct = 10'd8;
      repeat (5) @(negedge clk);
      num_correct = 10'd9;
      repeat (40) @(negedge clk);
      chk("auto_once", 64'(busy_cnt - b0), 64'd0);
      chk("auto_done", 64'(done_cnt - d0), 64'd1);

      // Single manual report
      num_correct = 10'h005;
      num_wrong   = 10'h002;
      cycles      = 32'h0000ABCD;
      base = rx_n;
      b0 = busy_cnt;
      d0 = done_cnt;
      report_req = 1'b1;
      @(negedge clk);
      report_req = 1'b0;
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_start_bit", 64'(txd), 64'd0);
      expect_line("single_line", base, "C=005 W=002 T=0000ABCD");
      wait_idle("single_idle");
      chk("single_busy_cycles", 64'(busy_cnt - b0), 64'd960);
      chk("single_done", 64'(done_cnt - d0), 64'd1);

      // Snapshot integrity
      num_correct = 10'h001;
      num_wrong   = 10'h000;
      cycles      = 32'h12345678;
      base = rx_n;
      report_req = 1'b1;
      @(negedge clk);
      report_req = 1'b0;
      repeat (200) @(negedge clk);
      cycles = 32'hFFFFFFFF;
      expect_line("snap_line", base, "C=001 W=000 T=12345678");
      wait_idle("snap_idle");

      // Coalescing
      num_correct = 10'h012;
      num_wrong   = 10'h034;
      cycles      = 32'hDEADBEEF;
      base = rx_n;
      b0 = busy_cnt;
      d0 = done_cnt;
      report_req = 1'b1;
      @(negedge clk);
      report_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         repeat (50) @(negedge clk);
         report_req = 1'b1;
         @(negedge clk);
         report_req = 1'b0;
      end
      repeat (100) @(negedge clk);
      num_correct = 10'h0AB;
      num_wrong   = 10'h0CD;
      cycles      = 32'h0BADF00D;
      expect_line("coal_line1", base, "C=012 W=034 T=DEADBEEF");
      expect_line("coal_line2", base + 24, "C=0AB W=0CD T=0BADF00D");
      wait_idle("coal_idle");
      chk("coal_busy_cycles", 64'(busy_cnt - b0), 64'd1920);
      chk("coal_done", 64'(done_cnt - d0), 64'd2);

      // Reset in the middle of char 7
      num_correct = 10'd0;
      num_wrong   = 10'd0;
      cycles      = 32'h00000001;
      report_req = 1'b1;
      @(negedge clk);
      report_req = 1'b0;
      repeat (290) @(negedge clk);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_txd", 64'(txd), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("rst_stay_idle", 64'(busy), 64'd0);
      base = rx_n;
      num_correct = 10'd4;
      num_wrong   = 10'd6;
      cycles      = 32'h00C0FFEE;
      @(negedge clk);
      chk("rst_rearm_busy", 64'(busy), 64'd1);
      expect_line("rst_auto_line", base, "C=004 W=006 T=00C0FFEE");
      wait_idle("rst_auto_idle");

      // Max values, disarmed then re-armed by reset
      num_correct = 10'h3FF;
      num_wrong   = 10'h3FF;
      cycles      = 32'hFFFFFFFF;
      repeat (5) @(negedge clk);
      chk("max_disarmed", 64'(busy), 64'd0);
      base = rx_n;
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("max_auto_busy", 64'(busy), 64'd1);
      expect_line("max_line", base, "C=3FF W=3FF T=FFFFFFFF");
      wait_idle("max_idle");
      repeat (40) @(negedge clk);
      chk("max_done_once", 64'(done_cnt - d0), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sudoku_report_tx.md
# sudoku_report_tx

Downstream reporting stage for the sudoku checker. It consumes the checker's `num_correct`, `num_wrong` and `cycles` counters and snapshots them when a run completes or on request. It then transmits one fixed-format ASCII line over an 8N1 UART TX pin, so board runs can be scored without a logic analyser.

## Interface
- `CLK_DIV`, 434: clock cycles per UART bit; legal range 2..65535.
- `NUM_PUZZLES`, 100: auto-report threshold on `num_correct + num_wrong`; legal range 1..1023.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `num_correct`  in  10  checker count of verified solutions.
- `num_wrong`  in  10  checker count of failed solutions.
- `cycles`  in  32  checker working-cycle count.
- `report_req`  in  1  single-cycle request for an immediate report.
- `txd`  out  1  UART serial output, idle high.
- `busy`  out  1  high while a line is being transmitted.
- `done`  out  1  one-cycle pulse when the last stop bit of a line completes.

## Operation
- Line format, 24 characters: `C=ccc W=www T=tttttttt` followed by CR (0x0D) and LF (0x0A).
  - `ccc` and `www` are 3 uppercase hex digits, MSB first, zero-padded.
  - `tttttttt` is 8 uppercase hex digits.
  - Hex digits are 0x30–0x39 and 0x41–0x46.
- Auto trigger:
  - `total = num_correct + num_wrong`, computed at 11 bits with no wrap.
  - The auto trigger fires once per reset, on the first cycle where `total >= NUM_PUZZLES`.
  - An internal `armed` flag is set by reset and cleared when the auto trigger fires.
- Manual trigger: `report_req` high at a clock edge.
- Snapshot: on an accepted trigger, all three counters are latched in the same edge. The transmitted line reflects only the snapshot, never live inputs.
- Triggers arriving while `busy`:
  - They set a single `pending` flag. Multiple triggers coalesce into one.
  - When the current line finishes, the pending report snapshots afresh at that edge and starts immediately.
- Simultaneous auto and manual trigger: they count as one report.
- State machine:
  - IDLE: `txd`=1. On a trigger or `pending`, snapshot, set char index 0, go to START.
  - START: `txd`=0 for `CLK_DIV` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLK_DIV` cycles, then go to STOP.
  - STOP: `txd`=1 for `CLK_DIV` cycles.
    - If char index < 23: increment the index, go to START.
    - Otherwise: pulse `done`, go to IDLE.
- Characters are sent back to back with no idle gap.
- Character selection is combinational from the char index and snapshot nibbles.

## Timing
- Reset values: `txd`=1, `busy`=0, `done`=0, `pending`=0, `armed`=1, FSM in IDLE, baud counter 0.
- Trigger accepted at edge N:
  - `busy`=1 and `txd`=0 (start bit) from edge N onward. No idle cycle is inserted.
  - The line occupies exactly 240·`CLK_DIV` cycles.
- End of line:
  - `done`=1 for the single cycle after the final stop-bit period ends.
  - `busy` falls in that same cycle.
  - If `pending` is set, `busy` instead stays high and `done` still pulses. The next start bit begins on that edge.
- Baud counter: counts 0..`CLK_DIV`-1 and wraps. A bit boundary occurs on wrap.
- Reset mid-line:
  - `txd` returns to 1 asynchronously and the partial character is abandoned.
  - `armed` is restored, so the auto trigger can fire again.
- `report_req` is ignored while `rst` is high.

## Structure
- Shared package `sudoku_report_pkg` holds:
  - `MSG_LEN`=24, `BITS_PER_CHAR`=10.
  - ASCII constants (`CH_C`, `CH_W`, `CH_T`, `CH_EQ`, `CH_SP`, `CH_CR`, `CH_LF`).
  - The FSM state typedef.
  - A nibble-to-ASCII-hex function.
- One sub-module, `uart_tx_byte`: start/data/stop serializer with a `CLK_DIV` baud counter and a valid/ready byte handshake.
- The top level owns trigger logic, snapshot registers and character sequencing.

## Test plan
- Benches use `CLK_DIV`=4.
- Single report: `report_req` pulse with inputs 0x005/0x002/0x0000ABCD -> `txd` decodes to `C=005 W=002 T=0000ABCD` CR LF; `busy` high for 960 cycles; one `done` pulse.
- Auto trigger: `NUM_PUZZLES`=10, `num_correct` ramps 0->7 with `num_wrong`=3 -> report starts on the edge `total` reaches 10. Further increments produce no second auto report.
- Snapshot integrity: change `cycles` from 0x12345678 to 0xFFFFFFFF mid-line -> the line still shows `T=12345678`.
- Coalescing: three `report_req` pulses during one line -> exactly one extra line, carrying the values at the end of the first line; two `done` pulses total.
- Reset mid-line: assert `rst` at char 7 -> `txd`=1 the same cycle; `busy`=0. After release, meeting the threshold triggers a new auto report.
- Max values: 0x3FF/0x3FF/0xFFFFFFFF -> `C=3FF W=3FF T=FFFFFFFF`; `total`=2046 causes no overflow misfire.
